// File: rtl/regfile_scoreboard_pkg.sv
// Shared core constants and types for the register file / scoreboard slice.
package regfile_scoreboard_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  // Architectural register address at the default register count.
  typedef logic [AW_DEF-1:0] regaddr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback and issue-claim signals of the register file with scoreboard.
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = 2,
  parameter int NWP   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRP-1:0][AW-1:0]   ra;
  logic [NRP-1:0][XLEN-1:0] rd;
  logic [NRP-1:0]           rbusy;
  logic [NWP-1:0]           we;
  logic [NWP-1:0][AW-1:0]   wa;
  logic [NWP-1:0][XLEN-1:0] wd;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     iss_ready;
  logic [AW:0]              busy_cnt;

  // Pipeline side: drives addresses, writebacks and claims.
  modport master (
    output ra, we, wa, wd, iss_valid, iss_rd,
    input  rd, rbusy, iss_ready, busy_cnt
  );

  // Register file side.
  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_rd,
    output rd, rbusy, iss_ready, busy_cnt
  );

endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port's write-bypass selector: a matching enabled write overrides the
// stored value, the highest-index matching port winning; x0 always reads zero.
module regfile_bypass_mux #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWP  = 2
) (
  input  logic [AW-1:0]             raddr,
  input  logic [XLEN-1:0]           stored,
  input  logic [NWP-1:0]            we,
  input  logic [NWP-1:0][AW-1:0]    wa,
  input  logic [NWP-1:0][XLEN-1:0]  wd,
  output logic [XLEN-1:0]           rdata,
  output logic                      hit
);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    rdata = stored;
    hit   = 1'b0;
    for (int j = 0; j < NWP; j++) begin
      if (we[j] && (wa[j] == raddr)) begin
        rdata = wd[j];
        hit   = 1'b1;
      end
    end
    if (raddr == '0) begin
      rdata = '0;
      hit   = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with a busy-bit scoreboard: zero-latency reads
// with writeback bypass, destination claims with WAW stall, live busy count.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = 2,
  parameter int NWP   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem_reg [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [AW:0]      busy_cnt_reg;
  logic [AW:0]      busy_cnt_next;
  logic             iss_hit;
  logic             iss_ok;
  logic             claim;

  // Storage: ports applied in ascending order so the highest port lands last; x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) mem_reg[k] <= '0;
    end else begin
      for (int j = 0; j < NWP; j++) begin
        if (bus.we[j] && (bus.wa[j] != '0)) mem_reg[bus.wa[j]] <= bus.wd[j];
      end
    end
  end

  // A same-cycle writeback to the claimed register retires the old producer, so no WAW stall.
  always_comb begin
    iss_hit = 1'b0;
    for (int j = 0; j < NWP; j++) begin
      if (bus.we[j] && (bus.wa[j] == bus.iss_rd)) iss_hit = 1'b1;
    end
  end

  assign iss_ok        = !rst_n || (bus.iss_rd == '0) || !busy_reg[bus.iss_rd] || iss_hit;
  assign claim         = bus.iss_valid && iss_ok && (bus.iss_rd != '0);
  assign bus.iss_ready = iss_ok;

  // Next busy vector: writebacks clear first, then a claim sets, so the new producer wins.
  always_comb begin
    busy_next = busy_reg;
    for (int j = 0; j < NWP; j++) begin
      if (bus.we[j]) busy_next[bus.wa[j]] = 1'b0;
    end
    if (claim) busy_next[bus.iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
    busy_cnt_next = '0;
    for (int k = 0; k < NREGS; k++) begin
      busy_cnt_next = busy_cnt_next + (AW+1)'(busy_next[k]);
    end
  end

  // Busy vector and its popcount are registered together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign bus.busy_cnt = busy_cnt_reg;

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [XLEN-1:0] mux_data;
    logic            mux_hit;

    regfile_bypass_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWP  (NWP)
    ) u_mux (
      .raddr  (bus.ra[gi]),
      .stored (mem_reg[bus.ra[gi]]),
      .we     (bus.we),
      .wa     (bus.wa),
      .wd     (bus.wd),
      .rdata  (mux_data),
      .hit    (mux_hit)
    );

    // Reset masks the bypass path too, so in-flight write data never shows during reset.
    assign bus.rd[gi]    = rst_n ? mux_data : '0;
    assign bus.rbusy[gi] = rst_n && busy_reg[bus.ra[gi]] && !mux_hit;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: architectural register count, power of two, at least 2.
REQ-003 SHALL have parameter NRP, default 2: number of read ports.
REQ-004 SHALL have parameter NWP, default 2: number of write (writeback) ports.
REQ-005 SHALL derive AW = $clog2(NREGS) as the address width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port ra, input, NRP x AW bits: read addresses.
REQ-009 SHALL have port rd, output, NRP x XLEN bits: read data.
REQ-010 SHALL have port rbusy, output, NRP bits: the operand on this read port is pending and its rd value is not valid.
REQ-011 SHALL have port we, input, NWP bits: write enables.
REQ-012 SHALL have port wa, input, NWP x AW bits: write addresses.
REQ-013 SHALL have port wd, input, NWP x XLEN bits: write data.
REQ-014 SHALL have port iss_valid, input, 1 bit: an instruction requests to claim a destination register.
REQ-015 SHALL have port iss_rd, input, AW bits: the destination register being claimed.
REQ-016 SHALL have port iss_ready, output, 1 bit: the claim is accepted this cycle.
REQ-017 SHALL have port busy_cnt, output, AW+1 bits: number of registers currently marked busy.

Function
REQ-018 SHALL hold NREGS x XLEN storage and an NREGS-bit busy vector.
REQ-019 SHALL hardwire register 0: reads return 0, writes are ignored, and it is never marked busy.
REQ-020 SHALL perform reads combinationally with zero latency.
REQ-021 SHALL bypass a same-cycle write: if we[j] is high and wa[j] equals ra[i] (nonzero), rd[i] shall equal wd[j].
REQ-022 SHALL let the highest-index write port win when several enabled ports target the same address, for both storage and bypass.
REQ-023 SHALL drive rbusy[i] = busy[ra[i]] AND NOT (a same-cycle write to ra[i]).
REQ-024 SHALL drive iss_ready high when iss_rd is 0, or when busy[iss_rd] is low, or when a same-cycle write targets iss_rd. Otherwise iss_ready is low (WAW stall).
REQ-025 SHALL set busy[iss_rd] at the next edge on an accepted claim (iss_valid AND iss_ready AND iss_rd not 0).
REQ-026 SHALL clear busy[wa[j]] at the next edge on each enabled write.
REQ-027 SHALL let a set win when a claim and a write target the same register in the same cycle, so the register stays busy for the new producer.
REQ-028 SHALL update storage on a write whether or not the register is busy; no ordering check is made.
REQ-029 SHALL keep busy_cnt registered and exactly equal to the popcount of the busy vector after every edge.
REQ-030 SHALL produce no X on any output from any defined input; out-of-range addresses cannot occur because NREGS is a power of two.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously clear all storage, the busy vector and busy_cnt, with effect independent of clk.
REQ-032 SHALL, during reset, drive rd = 0, rbusy = 0, busy_cnt = 0, and iss_ready = 1.
REQ-033 SHALL discard claims and writes in flight when reset is asserted mid-operation; no pending state survives reset.

Structure
REQ-034 SHALL take the default XLEN and NREGS constants and a regaddr_t typedef from the shared core package.
REQ-035 SHALL place the write-priority and bypass mux in one sub-module, regfile_bypass_mux, instantiated once per read port.

Verification
REQ-036 SHALL cover reset-then-read: after reset, any ra gives rd = 0 and rbusy = 0.
REQ-037 SHALL cover a bypass conflict: we = 2'b11, wa = {5, 5}, wd = {0xAAAA, 0x5555}, ra[0] = 5 gives rd[0] = port-1 data in the same cycle, and register 5 holds that value afterward.
REQ-038 SHALL cover a scoreboard claim: claim x7, then the next cycle ra[1] = 7 gives rbusy[1] = 1 and busy_cnt = 1; a write of x7 = 0x1234 gives rbusy = 0 and rd = 0x1234 in the same cycle, and busy_cnt = 0 after the edge.
REQ-039 SHALL cover a WAW stall: with x3 busy, iss_rd = 3 and no write gives iss_ready = 0; adding a write to x3 in the same cycle gives iss_ready = 1, and x3 remains busy after the edge.
REQ-040 SHALL cover x0: a write of 0xFFFF to x0 followed by a read gives 0; a claim on x0 gives iss_ready = 1 and busy_cnt unchanged.
REQ-041 SHALL cover reset mid-operation: with 4 registers busy, pulsing rst_n low between clock edges gives busy_cnt = 0 immediately and all rd = 0.
